// File: rtl/conv_wb_pkg.sv
// Shared types for the convolution output writeback path.
// Entry field widths match the default external memory geometry (1<<20 x 32).
package conv_wb_pkg;

   localparam int WB_ADDR_W = 20;
   localparam int WB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } wb_state_t;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] wdata;
   } wb_entry_t;

   function automatic int map_total(input int w, input int h, input int c);
      return w * h * c;
   endfunction

   // One extra bit so the coordinate bus can carry out-of-range values.
   function automatic int coord_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/conv_output_writeback_fifo.sv
// Small synchronous write buffer of address/data entries with full/empty flags.
module wb_fifo
   import conv_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage carries no reset; the pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/conv_output_writeback.sv
// Rescales accumulator results, buffers them, and writes one output feature map
// to external memory in channel-major order while tracking completion.
module conv_output_writeback
   import conv_wb_pkg::*;
#(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int ACCUMULATION_WIDTH = 32,
   parameter int EXT_MEM_HEIGHT     = 1 << 20,
   parameter int EXT_MEM_WIDTH      = 32,
   parameter int FEATURE_MAP_WIDTH  = 64,
   parameter int FEATURE_MAP_HEIGHT = 64,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int OUT_SHIFT          = 8,
   parameter int OUT_BASE_ADDR      = 0,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic                                   clk,
   input  logic                                   arst_in,
   input  logic                                   start,
   input  logic [ACCUMULATION_WIDTH-1:0]          acc_data,
   input  logic                                   acc_valid,
   output logic                                   acc_ready,
   input  logic [$clog2(FEATURE_MAP_WIDTH):0]     acc_x,
   input  logic [$clog2(FEATURE_MAP_HEIGHT):0]    acc_y,
   input  logic [$clog2(OUTPUT_NB_CHANNELS):0]    acc_ch,
   output logic                                   mem_we,
   input  logic                                   mem_ready,
   output logic [$clog2(EXT_MEM_HEIGHT)-1:0]      mem_addr,
   output logic [EXT_MEM_WIDTH-1:0]               mem_wdata,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   coord_err,
   output logic [$clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS):0] written_cnt
);

   localparam int TOTAL  = map_total(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
   localparam int CNT_W  = $clog2(TOTAL) + 1;
   localparam int ADDR_W = $clog2(EXT_MEM_HEIGHT);
   localparam int SUM_W  = ACCUMULATION_WIDTH + 1;
   localparam int XW     = coord_width(FEATURE_MAP_WIDTH);
   localparam int YW     = coord_width(FEATURE_MAP_HEIGHT);
   localparam int CHW    = coord_width(OUTPUT_NB_CHANNELS);

   localparam logic [XW-1:0]  X_LIM  = XW'(FEATURE_MAP_WIDTH);
   localparam logic [YW-1:0]  Y_LIM  = YW'(FEATURE_MAP_HEIGHT);
   localparam logic [CHW-1:0] CH_LIM = CHW'(OUTPUT_NB_CHANNELS);

   // Half an output LSB; collapses to zero when no shift is applied.
   localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'((SUM_W'(1) << OUT_SHIFT) >> 1);
   localparam logic signed [SUM_W-1:0] SAT_MAX    = SUM_W'((1 << (IO_DATA_WIDTH - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN    = ~SAT_MAX;

   wb_state_t                   state;
   wb_entry_t                   push_entry;
   wb_entry_t                   head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        coord_ok;
   logic                        accept;
   logic                        push;
   logic                        pop;
   logic signed [SUM_W-1:0]     acc_ext;
   logic signed [SUM_W-1:0]     rounded;
   logic signed [SUM_W-1:0]     shifted;
   logic signed [IO_DATA_WIDTH-1:0] sat_val;
   logic [ADDR_W-1:0]           push_addr;

   assign coord_ok  = (acc_x < X_LIM) && (acc_y < Y_LIM) && (acc_ch < CH_LIM);
   assign acc_ready = (state == RUN) && !fifo_full;
   assign accept    = acc_valid && acc_ready;
   assign push      = accept && coord_ok;
   assign mem_we    = !fifo_empty;
   assign pop       = mem_we && mem_ready;
   assign busy      = (state == RUN);

   assign acc_ext = {acc_data[ACCUMULATION_WIDTH-1], acc_data};
   assign rounded = acc_ext + ROUND_BIAS;
   assign shifted = rounded >>> OUT_SHIFT;

   always_comb begin
      sat_val = shifted[IO_DATA_WIDTH-1:0];
      if (shifted > SAT_MAX) begin
         sat_val = SAT_MAX[IO_DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         sat_val = SAT_MIN[IO_DATA_WIDTH-1:0];
      end
   end

   // Modular arithmetic in the address width gives the required wrap for free.
   assign push_addr = ADDR_W'(OUT_BASE_ADDR)
                    + ((ADDR_W'(acc_ch) * ADDR_W'(FEATURE_MAP_HEIGHT) + ADDR_W'(acc_y))
                       * ADDR_W'(FEATURE_MAP_WIDTH))
                    + ADDR_W'(acc_x);

   assign push_entry.addr  = WB_ADDR_W'(push_addr);
   assign push_entry.wdata = WB_DATA_W'({{(EXT_MEM_WIDTH-IO_DATA_WIDTH){sat_val[IO_DATA_WIDTH-1]}}, sat_val});

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (arst_in),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Stale storage behind an empty buffer must not leak onto the memory bus.
   assign mem_addr  = fifo_empty ? '0 : ADDR_W'(head.addr);
   assign mem_wdata = fifo_empty ? '0 : EXT_MEM_WIDTH'(head.wdata);

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         state       <= IDLE;
         written_cnt <= '0;
         done        <= 1'b0;
         coord_err   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= RUN;
                  written_cnt <= '0;
                  done        <= 1'b0;
                  coord_err   <= 1'b0;
               end
            end
            RUN: begin
               if (accept && !coord_ok) begin
                  coord_err <= 1'b1;
               end
               if (pop) begin
                  written_cnt <= written_cnt + CNT_W'(1);
                  if (written_cnt == CNT_W'(TOTAL - 1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
